// File: rtl/cam_insert_ctrl.sv
// cam_insert_ctrl: insert/delete controller in front of a CAM, tracking
// occupancy and allocating the lowest free entry on insert.
module cam_insert_ctrl #(
    parameter int DATA_WIDTH = 5,
    parameter int DATA_SIZE  = 1 << DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_SIZE-1:0]  req_key,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_status,
    output logic [DATA_WIDTH-1:0] rsp_index,
    output logic [DATA_WIDTH:0]   count,
    output logic                  cam_write,
    output logic [DATA_WIDTH-1:0] cam_write_index,
    output logic [DATA_SIZE-1:0]  cam_write_data,
    output logic                  cam_search,
    output logic [DATA_SIZE-1:0]  cam_search_data,
    input  logic                  cam_search_valid,
    input  logic [DATA_WIDTH-1:0] cam_search_index
);
    localparam logic [2:0] INIT   = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] SEARCH = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] clr_q, clr_d;
    logic [DATA_SIZE-1:0]  occ_q, occ_d;
    logic [DATA_WIDTH:0]   count_q, count_d;
    logic                  op_q, op_d;
    logic [DATA_SIZE-1:0]  key_q, key_d;
    logic [DATA_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            status_q, status_d;
    logic [DATA_WIDTH-1:0] free_idx;
    logic                  hit, full;

    // Scan downward so the lowest-numbered free entry is the one left standing.
    always_comb begin
        free_idx = '0;
        for (int i = DATA_SIZE - 1; i >= 0; i--)
            if (!occ_q[i]) free_idx = DATA_WIDTH'(i);
    end

    // A CAM match on an entry we never filled is stale and counts as a miss.
    assign hit  = cam_search_valid & occ_q[cam_search_index];
    assign full = count_q == (DATA_WIDTH+1)'(DATA_SIZE);

    always_comb begin
        state_d  = state_q;
        clr_d    = clr_q;
        occ_d    = occ_q;
        count_d  = count_q;
        op_d     = op_q;
        key_d    = key_q;
        idx_d    = idx_q;
        status_d = status_q;
        case (state_q)
            INIT: begin
                clr_d   = clr_q + 1'b1;
                state_d = (clr_q == DATA_WIDTH'(DATA_SIZE - 1)) ? IDLE : INIT;
            end
            IDLE: if (req_valid) begin
                op_d     = req_op;
                key_d    = req_key;
                idx_d    = '0;
                status_d = 2'b11;
                state_d  = (req_key == '0) ? RESP : SEARCH;
            end
            SEARCH: state_d = WAIT;
            WAIT: if (!op_q) begin
                state_d  = (!hit && !full) ? WRITE : RESP;
                status_d = hit ? 2'b01 : full ? 2'b10 : 2'b00;
                idx_d    = hit ? cam_search_index : full ? '0 : free_idx;
            end else begin
                state_d  = hit ? WRITE : RESP;
                status_d = hit ? 2'b00 : 2'b11;
                idx_d    = hit ? cam_search_index : '0;
            end
            WRITE: begin
                occ_d[idx_q] = !op_q;
                count_d      = op_q ? count_q - 1'b1 : count_q + 1'b1;
                status_d     = 2'b00;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            clr_q    <= '0;
            occ_q    <= '0;
            count_q  <= '0;
            op_q     <= 1'b0;
            key_q    <= '0;
            idx_q    <= '0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
            op_q     <= op_d;
            key_q    <= key_d;
            idx_q    <= idx_d;
            status_q <= status_d;
        end
    end

    assign req_ready       = state_q == IDLE;
    assign rsp_valid       = state_q == RESP;
    assign rsp_status      = rsp_valid ? status_q : 2'b00;
    assign rsp_index       = rsp_valid ? idx_q : '0;
    assign count           = count_q;
    assign cam_write       = state_q == INIT || state_q == WRITE;
    assign cam_write_index = state_q == INIT ? clr_q : state_q == WRITE ? idx_q : '0;
    assign cam_write_data  = (state_q == WRITE && !op_q) ? key_q : '0;
    assign cam_search      = state_q == SEARCH;
    assign cam_search_data = cam_search ? key_q : '0;
endmodule

// File: tb/tb_cam_insert_ctrl.sv
// tb_cam_insert_ctrl: directed insert/delete traffic against a behavioural CAM,
// responses and CAM writes checked by a queue-based scoreboard.
module tb_cam_insert_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [31:0] req_key = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [4:0]  rsp_index;
    logic [5:0]  count;
    logic        cam_write;
    logic [4:0]  cam_write_index;
    logic [31:0] cam_write_data;
    logic        cam_search;
    logic [31:0] cam_search_data;
    logic        cam_search_valid = 1'b0;
    logic [4:0]  cam_search_index = '0;

    cam_insert_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_key(req_key), .rsp_valid(rsp_valid),
        .rsp_status(rsp_status), .rsp_index(rsp_index), .count(count),
        .cam_write(cam_write), .cam_write_index(cam_write_index),
        .cam_write_data(cam_write_data), .cam_search(cam_search),
        .cam_search_data(cam_search_data), .cam_search_valid(cam_search_valid),
        .cam_search_index(cam_search_index)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] st; logic [4:0] ix; int cy; int cn; } rsp_t;
    typedef struct { logic [4:0] ix; logic [31:0] d; } wr_t;
    rsp_t expq[$];
    wr_t  wexp[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   armed = 0;
    bit   ghost_en = 0;
    logic [4:0] ghost_idx = '0;
    logic [31:0] mem [32];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CAM; ghost mode fakes a match on a chosen entry.
    always @(posedge clk) begin
        if (cam_write) mem[cam_write_index] <= cam_write_data;
        cam_search_valid <= 1'b0;
        cam_search_index <= '0;
        if (cam_search) begin
            for (int i = 31; i >= 0; i--)
                if (mem[i] == cam_search_data) begin
                    cam_search_valid <= 1'b1;
                    cam_search_index <= 5'(i);
                end
            if (ghost_en) begin
                cam_search_valid <= 1'b1;
                cam_search_index <= ghost_idx;
            end
        end
    end

    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        check(!(cam_write && cam_search), "write_search_exclusive", {cam_write, cam_search}, 0);
        if (rsp_valid) begin
            if (expq.size() == 0) check(0, "unexpected_rsp", {rsp_status, rsp_index}, 0);
            else begin
                rsp_t e;
                e = expq.pop_front();
                check({rsp_status, rsp_index, count} === {e.st, e.ix, 6'(e.cn)}, "rsp_status_index_count",
                      {rsp_status, rsp_index, count}, {e.st, e.ix, 6'(e.cn)});
                check(cyc == e.cy, "rsp_latency", cyc, e.cy);
            end
        end
        if (armed && cam_write) begin
            if (wexp.size() == 0) check(0, "unexpected_cam_write", {cam_write_index, cam_write_data}, 0);
            else begin
                wr_t w;
                w = wexp.pop_front();
                check({cam_write_index, cam_write_data} === {w.ix, w.d}, "cam_write_index_data",
                      {cam_write_index, cam_write_data}, {w.ix, w.d});
            end
        end
    end

    task automatic do_reset();
        armed = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({req_ready, rsp_valid, rsp_status, rsp_index, cam_search, cam_search_data} == '0,
              "reset_outputs_idle", {req_ready, rsp_valid, rsp_status, rsp_index, cam_search}, 0);
        check({cam_write, cam_write_index, cam_write_data, count} == {1'b1, 5'd0, 32'd0, 6'd0},
              "reset_cam_write", {cam_write, cam_write_index, cam_write_data}, 64'h1_0000_0000_0000 >> 27);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check({req_ready, cam_write, cam_write_index, cam_write_data} == {1'b0, 1'b1, 5'(k), 32'd0},
                  "init_clear_write", {req_ready, cam_write, cam_write_index}, {2'b01, 5'(k)});
            @(negedge clk);
        end
        check({req_ready, cam_write, count} == {1'b1, 1'b0, 6'd0}, "init_done_ready",
              {req_ready, cam_write, count}, {2'b10, 6'd0});
        armed = 1;
    endtask

    task automatic req(input logic op, input logic [31:0] key, input logic [1:0] st, input logic [4:0] ix,
                       input int lat, input int cn, input bit wr, input logic [4:0] wix,
                       input logic [31:0] wd, input int hold);
        int n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin check(0, "ready_timeout", 0, 1); return; end
        expq.push_back('{st: st, ix: ix, cy: cyc + lat, cn: cn});
        if (wr) wexp.push_back('{ix: wix, d: wd});
        req_op = op;
        req_key = key;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (hold) begin @(posedge clk); #1; end
        req_valid = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (expq.size() != 0) begin check(0, "rsp_timeout", expq.size(), 0); expq.delete(); end
        check(wexp.size() == 0, "cam_write_missing", wexp.size(), 0);
        wexp.delete();
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        req(0, 7, 2'b00, 0, 4, 1, 1, 0, 7, 2);
        req(0, 7, 2'b01, 0, 3, 1, 0, 0, 0, 0);
        req(1, 7, 2'b00, 0, 4, 0, 1, 0, 0, 0);
        req(1, 7, 2'b11, 0, 3, 0, 0, 0, 0, 0);
        req(0, 0, 2'b11, 0, 1, 0, 0, 0, 0, 0);
        req(1, 0, 2'b11, 0, 1, 0, 0, 0, 0, 0);
        ghost_en = 1;
        ghost_idx = 9;
        req(0, 100, 2'b00, 0, 4, 1, 1, 0, 100, 0);
        req(1, 200, 2'b11, 0, 3, 1, 0, 0, 0, 0);
        ghost_en = 0;
        req(1, 100, 2'b00, 0, 4, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 32; k++) req(0, 32'(k), 2'b00, 5'(k - 1), 4, k, 1, 5'(k - 1), 32'(k), 0);
        req(0, 33, 2'b10, 0, 3, 32, 0, 0, 0, 0);
        req(0, 5, 2'b01, 4, 3, 32, 0, 0, 0, 0);
        req(0, 32, 2'b01, 31, 3, 32, 0, 0, 0, 0);
        req(1, 7, 2'b00, 6, 4, 31, 1, 6, 0, 0);
        req(0, 40, 2'b00, 6, 4, 32, 1, 6, 40, 0);
        req(1, 1, 2'b00, 0, 4, 31, 1, 0, 0, 0);
        req(1, 32, 2'b00, 31, 4, 30, 1, 31, 0, 0);
        req(0, 50, 2'b00, 0, 4, 31, 1, 0, 50, 0);
        req(0, 51, 2'b00, 31, 4, 32, 1, 31, 51, 0);
        req(0, 52, 2'b10, 0, 3, 32, 0, 0, 0, 0);
        req_op = 1'b0;
        req_key = 60;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();
        req(0, 7, 2'b00, 0, 4, 1, 1, 0, 7, 0);
        repeat (5) @(negedge clk);
        check(expq.size() == 0 && wexp.size() == 0, "queues_drained", expq.size() + wexp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cam_insert_ctrl.md
CAM_INSERT_CTRL -- requirements
Module: cam_insert_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 5: CAM index width.
REQ-002 Parameter DATA_SIZE, default 1<<DATA_WIDTH (32): CAM entry count and key width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request offered.
REQ-006 req_ready  out  1  controller accepts request this cycle.
REQ-007 req_op  in  1  0 = insert, 1 = delete.
REQ-008 req_key  in  DATA_SIZE  key to insert/delete.
REQ-009 rsp_valid  out  1  one-cycle response pulse.
REQ-010 rsp_status  out  2  00 DONE, 01 DUPLICATE, 10 FULL, 11 NOT_FOUND/BAD_KEY.
REQ-011 rsp_index  out  DATA_WIDTH  entry index written, found, or cleared; 0 on FULL/NOT_FOUND/BAD_KEY.
REQ-012 count  out  DATA_WIDTH+1  number of occupied entries.
REQ-013 cam_write / cam_write_index / cam_write_data  out  1 / DATA_WIDTH / DATA_SIZE  drive downstream CAM write port.
REQ-014 cam_search / cam_search_data  out  1 / DATA_SIZE  drive downstream CAM search port.
REQ-015 cam_search_valid / cam_search_index  in  1 / DATA_WIDTH  CAM search result, valid the cycle after cam_search is high.

Function
REQ-016 FSM states SHALL be INIT, IDLE, SEARCH, WAIT, WRITE, RESP.
REQ-017 INIT: 5-bit clear counter 0..DATA_SIZE-1; each cycle cam_write=1, cam_write_index=counter, cam_write_data=0; after index DATA_SIZE-1 -> IDLE (DATA_SIZE cycles total).
REQ-018 req_ready SHALL be 1 only in IDLE; req_valid in any other state is ignored, not queued.
REQ-019 Handshake (req_valid & req_ready at edge) latches req_op/req_key; key==0 -> RESP with status 11 (key 0 reserved as the empty marker); else -> SEARCH.
REQ-020 SEARCH: cam_search=1, cam_search_data=latched key for exactly one cycle -> WAIT.
REQ-021 WAIT: hit = cam_search_valid & occupancy[cam_search_index]; a CAM match on an unoccupied entry is a miss.
REQ-022 Insert: hit -> RESP, status 01, rsp_index=cam_search_index; miss & count==DATA_SIZE -> RESP, status 10; miss & not full -> WRITE at lowest-numbered free entry.
REQ-023 Delete: hit -> WRITE with data 0 at cam_search_index; miss -> RESP, status 11.
REQ-024 WRITE: cam_write=1 one cycle; insert sets occupancy bit and count+1, delete clears it and count-1; -> RESP, status 00.
REQ-025 RESP: rsp_valid=1 one cycle with status/index; -> IDLE. No response backpressure.
REQ-026 Latency from accept edge to rsp_valid: 4 cycles on write paths, 3 on DUPLICATE/FULL/NOT_FOUND, 1 on BAD_KEY.
REQ-027 cam_write and cam_search SHALL never be high in the same cycle; both 0 outside INIT/SEARCH/WRITE.
REQ-028 Duplicate check takes precedence over full: an insert of a present key when full returns 01.
REQ-029 count SHALL saturate-free range 0..DATA_SIZE; free-entry priority encoder SHALL cover all DATA_SIZE entries including index DATA_SIZE-1.

Reset
REQ-030 rst at any edge, including mid-request, SHALL force INIT, clear counter 0, occupancy 0, count 0; in-flight request is dropped with no response.
REQ-031 Reset values: req_ready 0, rsp_valid 0, rsp_status 00, rsp_index 0, cam_search 0, cam_search_data 0; cam_write=1 with index 0, data 0 (INIT starts).

Verification
REQ-032 Reset then 32 idle cycles -> 32 cam_write pulses, indices 0..31, data 0; req_ready rises next cycle; count 0.
REQ-033 Insert key 7 (CAM miss) -> cam_write index 0 data 7, rsp_valid 4 cycles after accept, status 00, index 0, count 1; re-insert 7 (CAM hit idx 0) -> status 01, index 0, no cam_write.
REQ-034 Insert 32 distinct keys 1..32 -> indices 0..31, count 32; insert 33 -> status 10; insert 5 -> status 01 index 4.
REQ-035 Delete key 7 at index 0 -> cam_write index 0 data 0, status 00, count decrements; delete 7 again -> status 11; next insert takes index 0.
REQ-036 Insert key 0 -> status 11 one cycle after accept, no CAM activity.
REQ-037 Assert rst in WAIT -> no rsp_valid, INIT rerun, count 0.
